aes_spi_master: RTL and testbench

//  Initiator end of the AES SPI link. Serialises a 128-bit plaintext and a
//  128/192/256-bit key to the AES SPI Slave over SIMO, LSB first.

---
 rtl/aes_spi_master_if.sv | 30 +++
 rtl/aes_spi_master.sv | 167 ++++++++++++++++
 tb/tb_aes_spi_master.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_spi_master_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_spi_master_if
// Brief    : Host-side request/result bus plus the serial link to the Slave.
// Revision : 1.0 - initial release
// ============================================================================
interface aes_spi_master_if;
    logic         start;
    logic [1:0]   size;
    logic [127:0] msg_in;
    logic [255:0] key_in;
    logic         SOMI;
    logic         SIMO;
    logic         CSS;
    logic         mode;
    logic         busy;
    logic         done;
    logic [127:0] result_out;

    modport master (
        input  start, size, msg_in, key_in, SOMI,
        output SIMO, CSS, mode, busy, done, result_out
    );

    modport slave (
        output start, size, msg_in, key_in, SOMI,
        input  SIMO, CSS, mode, busy, done, result_out
    );
endinterface
`default_nettype wire

// File: rtl/aes_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : aes_spi_master
// Brief    : Serialises plaintext and key to the AES SPI Slave, then collects
//            the 128-bit ciphertext after the core latency.
// Revision : 1.0 - initial release
// ============================================================================
module aes_spi_master #(
    parameter int WAIT_CYCLES = 64,
    parameter int MSG_W       = 128
) (
    input  wire logic        clk,
    input  wire logic        reset,
    aes_spi_master_if.master bus
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SEND_MSG = 3'd1;
    localparam logic [2:0] S_SEND_KEY = 3'd2;
    localparam logic [2:0] S_WAIT     = 3'd3;
    localparam logic [2:0] S_RECV     = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [8:0]       cnt_q, cnt_d;
    logic [MSG_W-1:0] msg_q, msg_d;
    logic [255:0]     key_q, key_d;
    logic [1:0]       size_q, size_d;
    logic [MSG_W-1:0] shift_q, shift_d;
    logic [MSG_W-1:0] result_q, result_d;
    logic             simo_q, simo_d;
    logic             css_q, css_d;
    logic             mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [8:0]       key_len;

    // size=11 is treated as a 256-bit key
    always_comb begin
        case (size_q)
            2'b00:   key_len = 9'd128;
            2'b01:   key_len = 9'd192;
            default: key_len = 9'd256;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        msg_d    = msg_q;
        key_d    = key_q;
        size_d   = size_q;
        shift_d  = shift_q;
        result_d = result_q;
        simo_d   = simo_q;
        css_d    = css_q;
        mode_d   = mode_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    msg_d   = bus.msg_in;
                    key_d   = bus.key_in;
                    size_d  = bus.size;
                    css_d   = 1'b0;
                    busy_d  = 1'b1;
                    simo_d  = bus.msg_in[0];
                    cnt_d   = 9'd1;
                    state_d = S_SEND_MSG;
                end
            end
            S_SEND_MSG: begin
                if (cnt_q == 9'(MSG_W)) begin
                    simo_d  = key_q[0];
                    cnt_d   = 9'd1;
                    state_d = S_SEND_KEY;
                end else begin
                    simo_d = msg_q[cnt_q[6:0]];
                    cnt_d  = cnt_q + 9'd1;
                end
            end
            S_SEND_KEY: begin
                // cnt == key_len means the last key bit has had its full cycle
                if (cnt_q == key_len) begin
                    mode_d  = 1'b1;
                    simo_d  = 1'b0;
                    cnt_d   = 9'd0;
                    state_d = S_WAIT;
                end else begin
                    simo_d = key_q[cnt_q[7:0]];
                    cnt_d  = cnt_q + 9'd1;
                end
            end
            S_WAIT: begin
                if (cnt_q == 9'(WAIT_CYCLES - 1)) begin
                    cnt_d   = 9'd0;
                    state_d = S_RECV;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            S_RECV: begin
                shift_d[cnt_q[6:0]] = bus.SOMI;
                if (cnt_q == 9'(MSG_W - 1)) begin
                    cnt_d   = 9'd0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            S_DONE: begin
                result_d = shift_q;
                done_d   = 1'b1;
                css_d    = 1'b1;
                mode_d   = 1'b0;
                busy_d   = 1'b0;
                cnt_d    = 9'd0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 9'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 9'd0;
            msg_q    <= '0;
            key_q    <= '0;
            size_q   <= 2'b00;
            shift_q  <= '0;
            result_q <= '0;
            simo_q   <= 1'b0;
            css_q    <= 1'b1;
            mode_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            msg_q    <= msg_d;
            key_q    <= key_d;
            size_q   <= size_d;
            shift_q  <= shift_d;
            result_q <= result_d;
            simo_q   <= simo_d;
            css_q    <= css_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.SIMO       = simo_q;
    assign bus.CSS        = css_q;
    assign bus.mode       = mode_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.result_out = result_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_spi_master
// Brief    : Randomised bench for aes_spi_master with a cycle-indexed model of
//            the link waveform and a Slave stand-in driving SOMI.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_spi_master;

    logic clk;
    logic reset;
    aes_spi_master_if bus();

    aes_spi_master #(.WAIT_CYCLES(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // Transaction handed from the driver to the model
    logic [127:0] exp_msg;
    logic [255:0] exp_key;
    logic [127:0] exp_resp;
    int           exp_kl;
    bit           tie_high;
    int           req_cnt = 0;

    // Model state, owned by the compare process
    int           ack_cnt = 0;
    bit           txn_active = 0;
    int           k = 0;
    logic [127:0] last_result = '0;
    int           l_end;
    int           idx;
    logic         e_simo;

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b want %b", nm, $time, act, exp);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
        end
    endtask

    function automatic int klen(input logic [1:0] s);
        return (s == 2'b00) ? 128 : ((s == 2'b01) ? 192 : 256);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Cycle k = k-th falling edge after the edge that accepted start.
    // Expected waveform: msg bits for k<128, key bits next, mode high from
    // 128+KLEN, 64 idle cycles, 128 SOMI samples, done at k = 321+KLEN.
    always @(negedge clk) begin
        if (!reset) begin
            txn_active  = 0;
            ack_cnt     = req_cnt;
            last_result = '0;
            chk_bit("rst_css",  bus.CSS,  1'b1);
            chk_bit("rst_mode", bus.mode, 1'b0);
            chk_bit("rst_busy", bus.busy, 1'b0);
            chk_bit("rst_done", bus.done, 1'b0);
            chk_bit("rst_simo", bus.SIMO, 1'b0);
            chk_vec("rst_result", bus.result_out, 128'h0);
            bus.SOMI = 1'($urandom_range(0, 1));
        end else if (txn_active) begin
            l_end = 321 + exp_kl;
            if (k < 128) begin
                e_simo = exp_msg[k[6:0]];
            end else if (k < 128 + exp_kl) begin
                idx    = k - 128;
                e_simo = exp_key[idx[7:0]];
            end else begin
                e_simo = 1'b0;
            end
            chk_bit("simo", bus.SIMO, e_simo);
            chk_bit("css",  bus.CSS,  k >= l_end);
            chk_bit("busy", bus.busy, k < l_end);
            chk_bit("mode", bus.mode, (k >= 128 + exp_kl) && (k < l_end));
            chk_bit("done", bus.done, k == l_end);
            if (k == l_end) begin
                chk_vec("result_at_done", bus.result_out, exp_resp);
                last_result = exp_resp;
                txn_active  = 0;
            end
            idx = k - (192 + exp_kl);
            if (txn_active && idx >= 0 && idx < 128)
                bus.SOMI = exp_resp[idx[6:0]];
            else
                bus.SOMI = tie_high ? 1'b1 : 1'($urandom_range(0, 1));
            k++;
        end else begin
            chk_bit("idle_css",  bus.CSS,  1'b1);
            chk_bit("idle_busy", bus.busy, 1'b0);
            chk_bit("idle_mode", bus.mode, 1'b0);
            chk_bit("idle_done", bus.done, 1'b0);
            chk_bit("idle_simo", bus.SIMO, 1'b0);
            chk_vec("idle_result", bus.result_out, last_result);
            bus.SOMI = tie_high ? 1'b1 : 1'($urandom_range(0, 1));
            if (req_cnt != ack_cnt) begin
                ack_cnt    = req_cnt;
                txn_active = 1;
                k          = 0;
            end
        end
    end

    // act: 0 plain, 1 extra start during SEND_KEY, 2 start during DONE,
    //      3 reset pulse mid-RECV
    task automatic run_txn(input logic [1:0] sz, input logic [127:0] m,
                           input logic [255:0] ky, input logic [127:0] rsp,
                           input int act, output int lat, output int nbits,
                           output int gap, output int ones, output int first_one);
        int cyc, last_bit, mode_at, kl;
        bit fin;
        kl = klen(sz);
        lat = -1; nbits = 0; gap = -1; ones = 0; first_one = -1;
        last_bit = -1; mode_at = -1; fin = 0;
        @(posedge clk); #1;
        exp_msg = m; exp_key = ky; exp_kl = kl; exp_resp = rsp;
        req_cnt++;
        bus.start = 1'b1; bus.size = sz; bus.msg_in = m; bus.key_in = ky;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.size   = 2'($urandom_range(0, 3));
        bus.msg_in = rnd128();
        bus.key_in = {rnd128(), rnd128()};
        cyc = 0;
        while (!fin && cyc < 1000) begin
            if (!bus.CSS && !bus.mode) begin
                nbits++;
                last_bit = cyc;
                if (bus.SIMO) begin
                    ones++;
                    if (first_one < 0) first_one = cyc;
                end
            end
            if (bus.mode && mode_at < 0) mode_at = cyc;
            if (bus.done) begin
                lat = cyc;
                fin = 1;
                chk_vec("txn_result", bus.result_out, rsp);
            end
            if (act == 1 && cyc == 228) bus.start = 1'b1;
            if (act == 1 && cyc == 229) bus.start = 1'b0;
            if (act == 2 && cyc == 320 + kl) bus.start = 1'b1;
            if (act == 3 && cyc == 128 + kl + 64 + 60) begin
                reset = 1'b0;
                #1;
                chk_bit("abort_css",  bus.CSS,  1'b1);
                chk_bit("abort_mode", bus.mode, 1'b0);
                chk_bit("abort_busy", bus.busy, 1'b0);
                chk_bit("abort_done", bus.done, 1'b0);
                chk_vec("abort_result", bus.result_out, 128'h0);
                fin = 1;
            end
            if (!fin) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        bus.start = 1'b0;
        if (act == 3) begin
            repeat (3) @(posedge clk);
            #1 reset = 1'b1;
        end else if (lat < 0) begin
            chk_int("done_timeout", cyc, 321 + kl);
        end
        if (mode_at >= 0 && last_bit >= 0) gap = mode_at - last_bit;
    endtask

    initial begin
        int lat, nbits, gap, ones, first_one, act;
        logic [1:0] sz;
        bus.start = 1'b0; bus.size = 2'b00; bus.msg_in = '0; bus.key_in = '0;
        tie_high = 0;
        exp_msg = '0; exp_key = '0; exp_resp = '0; exp_kl = 128;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk_bit("por_css",  bus.CSS,  1'b1);
        chk_bit("por_busy", bus.busy, 1'b0);
        chk_vec("por_result", bus.result_out, 128'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Known vectors; the Slave stand-in returns the published ciphertext
        run_txn(2'b00, 128'h3243f6a8885a308d313198a2e0370734,
                {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c},
                128'h3925841d02dc09fbdc118597196a0b32, 0, lat, nbits, gap, ones, first_one);
        chk_int("t1_latency", lat, 449);
        chk_int("t1_bits", nbits, 256);

        run_txn(2'b01, 128'h00112233445566778899aabbccddeeff,
                {64'h0, 192'h000102030405060708090a0b0c0d0e0f1011121314151617},
                128'hdda97ca4864cdfe06eaf70a0ec0d7191, 0, lat, nbits, gap, ones, first_one);
        chk_int("t2_latency", lat, 513);
        chk_int("t2_bits", nbits, 320);

        run_txn(2'b10, 128'h00112233445566778899aabbccddeeff,
                256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h8ea2b7ca516745bfeafc49904b496089, 0, lat, nbits, gap, ones, first_one);
        chk_int("t3_latency", lat, 577);
        chk_int("t3_bits", nbits, 384);
        chk_int("t3_mode_gap", gap, 1);

        // Bit order: single msg bit, SOMI tied high
        tie_high = 1;
        run_txn(2'b00, 128'h1, 256'h0, {128{1'b1}}, 0, lat, nbits, gap, ones, first_one);
        chk_int("t4_ones", ones, 1);
        chk_int("t4_first_one", first_one, 0);
        tie_high = 0;

        run_txn(2'b01, rnd128(), {rnd128(), rnd128()}, rnd128(), 1,
                lat, nbits, gap, ones, first_one);
        chk_int("t5_latency", lat, 513);

        run_txn(2'b11, rnd128(), {rnd128(), rnd128()}, rnd128(), 2,
                lat, nbits, gap, ones, first_one);
        chk_int("size11_latency", lat, 577);
        repeat (5) @(posedge clk);

        run_txn(2'b10, rnd128(), {rnd128(), rnd128()}, rnd128(), 3,
                lat, nbits, gap, ones, first_one);
        run_txn(2'b00, rnd128(), {rnd128(), rnd128()}, rnd128(), 0,
                lat, nbits, gap, ones, first_one);
        chk_int("after_abort_latency", lat, 449);

        for (int i = 0; i < 6; i++) begin
            sz  = 2'($urandom_range(0, 3));
            act = (i == 2) ? 1 : ((i == 4) ? 2 : 0);
            run_txn(sz, rnd128(), {rnd128(), rnd128()}, rnd128(), act,
                    lat, nbits, gap, ones, first_one);
            chk_int("rand_latency", lat, 321 + klen(sz));
            chk_int("rand_bits", nbits, 128 + klen(sz));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
